// File: rtl/fall_det_pkg.sv
// Shared types and helpers for the sequential fall detector.
package fall_det_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    QUAL  = 2'd1,
    ALARM = 2'd2,
    REARM = 2'd3
  } fd_state_e;

  // The qual counter only needs to reach HOLD_CNT-1 before the alarm fires.
  function automatic int qual_cnt_w(input int hold_cnt);
    return (hold_cnt <= 2) ? 1 : $clog2(hold_cnt);
  endfunction

endpackage

// File: rtl/threshold_cmp.sv
// Unsigned threshold compare with a hysteresis re-arm margin; shared by sensor blocks.
module threshold_cmp #(
  parameter int WIDTH = 8,
  parameter int HYST  = 2
) (
  input  logic [WIDTH-1:0] sensor_i,
  input  logic [WIDTH-1:0] factory_i,
  output logic             over_o,
  output logic             below_o
);

  // One extra bit so sensor + HYST never wraps back under the threshold.
  logic [WIDTH:0] sum_hyst;

  assign sum_hyst = {1'b0, sensor_i} + (WIDTH+1)'(HYST);
  assign over_o   = sensor_i >= factory_i;
  assign below_o  = sum_hyst < {1'b0, factory_i};

endmodule

// File: rtl/fall_detector_seq.sv
// Sequential fall detector: qualify HOLD_CNT over-threshold samples, latch alarm, re-arm with hysteresis.
// Build option FALL_PEAK_EN adds the peak_value output tracking the max sample of each event.
module fall_detector_seq
  import fall_det_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int HOLD_CNT = 4,
  parameter int HYST     = 2,
  parameter int COUNT_W  = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_valid,
  input  logic [WIDTH-1:0]   sensor_value,
  input  logic [WIDTH-1:0]   factory_value,
  input  logic               alarm_clear,
  output logic               fall_detected,
  output logic               fall_pulse,
  output logic               armed,
  output logic [COUNT_W-1:0] event_count
`ifdef FALL_PEAK_EN
  ,
  output logic [WIDTH-1:0]   peak_value
`endif
);

  localparam int CW = qual_cnt_w(HOLD_CNT);

  fd_state_e          state_q;
  logic [CW-1:0]      cnt_q;
  logic               fall_q, pulse_q, armed_q;
  logic [COUNT_W-1:0] evt_q;
  logic               over, below;

  threshold_cmp #(.WIDTH(WIDTH), .HYST(HYST)) u_cmp (
    .sensor_i  (sensor_value),
    .factory_i (factory_value),
    .over_o    (over),
    .below_o   (below)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
      pulse_q <= 1'b0;
      armed_q <= 1'b1;
      evt_q   <= '0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sample_valid && over) begin
            if (HOLD_CNT == 1) begin
              state_q <= ALARM;
              fall_q  <= 1'b1;
              pulse_q <= 1'b1;
              armed_q <= 1'b0;
              if (evt_q != '1) evt_q <= evt_q + COUNT_W'(1);
            end else begin
              state_q <= QUAL;
              cnt_q   <= CW'(1);
            end
          end
        end
        QUAL: begin
          if (sample_valid) begin
            if (!over) begin
              state_q <= IDLE;
              cnt_q   <= '0;
            end else if (int'(cnt_q) + 1 == HOLD_CNT) begin
              state_q <= ALARM;
              cnt_q   <= '0;
              fall_q  <= 1'b1;
              pulse_q <= 1'b1;
              armed_q <= 1'b0;
              if (evt_q != '1) evt_q <= evt_q + COUNT_W'(1);
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        ALARM: begin
          // Samples are ignored here; a clear always wins over a concurrent sample.
          if (alarm_clear) begin
            state_q <= REARM;
            fall_q  <= 1'b0;
          end
        end
        REARM: begin
          if (sample_valid && below) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fall_detected = fall_q;
  assign fall_pulse    = pulse_q;
  assign armed         = armed_q;
  assign event_count   = evt_q;

`ifdef FALL_PEAK_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_q <= '0;
    end else if (sample_valid) begin
      case (state_q)
        IDLE:        if (over) peak_q <= sensor_value;
        QUAL, ALARM: if (sensor_value > peak_q) peak_q <= sensor_value;
        default:     peak_q <= peak_q;
      endcase
    end
  end

  assign peak_value = peak_q;
`endif

endmodule

// File: tb/tb_fall_detector_seq.sv
// Scoreboard bench for fall_detector_seq: driver pushes model predictions, monitor pops and compares.
module tb_fall_detector_seq;

  localparam int WIDTH = 8, HOLD = 3, HYST = 2, CW = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             sample_valid = 1'b0;
  logic [WIDTH-1:0] sensor_value = '0;
  logic [WIDTH-1:0] factory_value = 8'd100;
  logic             alarm_clear = 1'b0;
  logic             fall_detected, fall_pulse, armed;
  logic [CW-1:0]    event_count;
`ifdef FALL_PEAK_EN
  logic [WIDTH-1:0] peak_value;
`endif

  fall_detector_seq #(.WIDTH(WIDTH), .HOLD_CNT(HOLD), .HYST(HYST), .COUNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_valid  (sample_valid),
    .sensor_value  (sensor_value),
    .factory_value (factory_value),
    .alarm_clear   (alarm_clear),
    .fall_detected (fall_detected),
    .fall_pulse    (fall_pulse),
    .armed         (armed),
    .event_count   (event_count)
`ifdef FALL_PEAK_EN
    ,
    .peak_value    (peak_value)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int fd; int fp; int arm; int cnt; int peak;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0, n_fail = 0;

  // Behavioural model: a run length of consecutive over samples plus two latch flags.
  bit m_alarm, m_rearm;
  int m_run, m_cnt, m_peak;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_alarm = 0; m_rearm = 0; m_run = 0; m_cnt = 0; m_peak = 0;
  endfunction

  task automatic step(input bit v, input int s, input bit clr);
    exp_t e;
    bit   pulse = 0;
    bit   idle_pre, qual_pre, alarm_pre;
    @(negedge clk);
    sample_valid = v;
    sensor_value = WIDTH'(s);
    alarm_clear  = clr;
    idle_pre  = !m_alarm && !m_rearm && m_run == 0;
    qual_pre  = m_run > 0;
    alarm_pre = m_alarm;
    if (m_alarm) begin
      if (clr) begin m_alarm = 0; m_rearm = 1; end
    end else if (m_rearm) begin
      if (v && s + HYST < int'(factory_value)) m_rearm = 0;
    end else if (v) begin
      if (s >= int'(factory_value)) begin
        m_run++;
        if (m_run == HOLD) begin
          m_alarm = 1; m_run = 0; pulse = 1;
          if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
      end else m_run = 0;
    end
    if (v) begin
      if (idle_pre && s >= int'(factory_value)) m_peak = s;
      else if ((qual_pre || alarm_pre) && s > m_peak) m_peak = s;
    end
    e.fd = m_alarm; e.fp = pulse; e.arm = !m_alarm && !m_rearm; e.cnt = m_cnt; e.peak = m_peak;
    q.push_back(e);
  endtask

  // Monitor: every clock edge the DUT presents a fresh set of registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fall_detected", int'(fall_detected), e.fd);
        chk("fall_pulse",    int'(fall_pulse),    e.fp);
        chk("armed",         int'(armed),         e.arm);
        chk("event_count",   int'(event_count),   e.cnt);
`ifdef FALL_PEAK_EN
        chk("peak_value",    int'(peak_value),    e.peak);
`endif
      end
    end
  end

  // Reset asserted mid-cycle; outputs are checked before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    sample_valid = 0; alarm_clear = 0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_fall_detected", int'(fall_detected), 0);
    chk("rst_fall_pulse",    int'(fall_pulse),    0);
    chk("rst_armed",         int'(armed),         1);
    chk("rst_event_count",   int'(event_count),   0);
`ifdef FALL_PEAK_EN
    chk("rst_peak_value",    int'(peak_value),    0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic full_cycle();
    step(1, 100, 0); step(1, 110, 0); step(1, 105, 0);
    idle(1);
    step(0, 0, 1);
    step(1, 97, 0);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic alarm, then clear and hysteresis re-arm.
    step(1, 100, 0); step(1, 120, 0); step(1, 101, 0);
    idle(2);
    step(0, 0, 1);
    step(1, 99, 0);
    step(1, 98, 0);
    step(1, 97, 0);

    // Broken run, then a clean one.
    step(1, 100, 0); step(1, 120, 0); step(1, 99, 0);
    step(1, 101, 0); step(1, 101, 0); step(1, 101, 0);
    step(1, 130, 1);
    step(1, 50, 0);

    // Gaps in sample_valid hold the qualification count.
    step(1, 100, 0); idle(5); step(1, 100, 0); step(1, 100, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    step(1, 97, 0);

    // Clear ignored outside ALARM.
    step(0, 0, 1); step(1, 100, 1); step(1, 0, 0);

    // Saturation of the event counter.
    for (int i = 0; i < 4; i++) full_cycle();

    // Reset mid-QUAL, then three overs are needed again.
    step(1, 101, 0); step(1, 101, 0);
    do_reset();
    step(1, 101, 0); step(1, 101, 0); step(1, 101, 0);
    step(1, 200, 0);
    do_reset();

    // Threshold at or below the hysteresis margin: REARM is sticky.
    step(1, 100, 0); step(1, 100, 0); step(1, 100, 0);
    step(0, 0, 1);
    factory_value = 8'd2;
    step(1, 0, 0); step(1, 0, 0); step(1, 255, 0);
    factory_value = 8'd100;
    do_reset();

    // Randomized traffic around the threshold.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(90, 115)), $urandom_range(0, 9) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
    end
    step(0, 0, 0);

    for (int i = 0; i < 4 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fall_detector_seq.md
Name: fall_detector_seq

Overview:
Sequential, parametrised fall detector. A fall is an accepted sample where sensor_value >= factory_value, unsigned. The alarm is raised only after HOLD_CNT consecutive accepted over-threshold samples. The alarm latches until software clears it, and the block re-arms only after the sensor drops below the threshold by a hysteresis margin. It sits between the sensor sampling front end and the alarm/interrupt logic, and supersedes the combinational detector.

Parameters:
WIDTH, 8, bit width of sensor_value and factory_value
HOLD_CNT, 4, consecutive over-threshold valid samples needed to raise the alarm (legal range >= 1)
HYST, 2, re-arm margin; re-arm needs sensor_value + HYST < factory_value
COUNT_W, 8, width of the saturating alarm event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
sample_valid  input  1  sensor_value is a new sample this cycle
sensor_value  input  WIDTH  measured sensor sample
factory_value  input  WIDTH  factory threshold, quasi-static, sampled with each valid sample
alarm_clear  input  1  one-cycle request to clear a latched alarm
fall_detected  output  1  latched alarm level
fall_pulse  output  1  one-cycle strobe on alarm entry
armed  output  1  detector is in IDLE or QUAL and can raise an alarm
event_count  output  COUNT_W  number of alarms raised, saturating

Behaviour:
- Reset: asynchronous and active-low (fixed).
  - State goes to IDLE; qual counter is 0.
  - fall_detected=0, fall_pulse=0, armed=1, event_count=0.
- Comparisons:
  - over = sensor_value >= factory_value.
  - below = (sensor_value + HYST) < factory_value, computed in WIDTH+1 bits with no wrap.
  - Both are evaluated only when sample_valid=1. Cycles with sample_valid=0 hold all state and counters.
- State machine, all outputs registered:
  - IDLE: valid&over -> ALARM if HOLD_CNT==1; otherwise QUAL with cnt=1. Any other input stays in IDLE.
  - QUAL:
    - valid&over with cnt+1==HOLD_CNT -> ALARM.
    - valid&over otherwise -> cnt+1, stay in QUAL.
    - valid&!over -> IDLE, cnt=0.
  - ALARM: alarm_clear -> REARM. Further samples are ignored. There is no re-entry pulse.
  - REARM: valid&below -> IDLE, cnt=0. Anything else stays in REARM.
- Latency: the qualifying sample is accepted at edge N.
  - fall_detected=1 and fall_pulse=1 from after edge N.
  - fall_pulse drops after edge N+1.
  - event_count increments at the same edge N, saturating at 2^COUNT_W-1.
- Output levels:
  - fall_detected=1 only in ALARM; it drops the edge after alarm_clear.
  - armed=1 in IDLE and QUAL.
- Simultaneous events:
  - alarm_clear in IDLE, QUAL or REARM is ignored.
  - In ALARM, alarm_clear plus a valid sample: clear wins.
- Boundary cases:
  - sensor_value==factory_value counts as over.
  - If factory_value <= HYST, below can never be true and the block stays in REARM until reset. This is intended fail-safe behaviour.
- Reset mid-operation returns to the reset values immediately, regardless of state.

Optional Feature:
FALL_PEAK_EN
- Defined:
  - Adds output peak_value [WIDTH-1:0], reset value 0.
  - peak_value is loaded with sensor_value on IDLE->QUAL (or IDLE->ALARM).
  - It then tracks the max over valid samples while in QUAL and ALARM.
  - It holds in REARM and IDLE.
  - A QUAL->IDLE abort leaves peak_value unchanged until the next load.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package fall_det_pkg: state enum (IDLE, QUAL, ALARM, REARM); a clog2-based width constant function for the qual counter.
- Sub-module threshold_cmp (combinational, WIDTH and HYST parameters): produces over and below. It is reused by other sensor blocks.

Test Plan:
- Config: WIDTH=8, HOLD_CNT=3, HYST=2, COUNT_W=2, factory=100.
- Basic alarm: valid samples 100,120,101 -> fall_detected=1 and fall_pulse high for one cycle after the third sample; event_count=1; armed=0.
- Broken run: 100,120,99 -> stays unarmed-free; back to IDLE with no alarm. Then 101,101,101 -> alarm raised.
- Valid gaps: 100, five cycles with sample_valid=0, 100, 100 -> alarm raised after the third valid sample.
- Clear and re-arm:
  - alarm_clear in ALARM -> fall_detected=0, REARM.
  - Sample 99 (101 not < 100) -> stays in REARM.
  - Sample 97 -> IDLE, armed=1.
  - Simultaneous clear plus sample in ALARM -> REARM.
- Saturation: four full alarm/clear/re-arm cycles -> event_count=3 and holds at 3.
- Reset: rst_n pulsed low mid-QUAL (cnt=2) and mid-ALARM -> all outputs return to reset values asynchronously. The next three over samples are needed to alarm again.
